// File: rtl/result_pkg.sv
// result_pkg: shared types and helpers for the result accumulator.
// Optional feature macro used by this slice: RESULT_RELU_EN (ReLU before saturation).
package result_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    POST = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int OUT_W  = 16;
  localparam int DATA_W = 32;

  localparam logic signed [63:0] OUT_MAX = 64'sd32767;
  localparam logic signed [63:0] OUT_MIN = -64'sd32768;

  // Clamp a wide signed value into the signed 16-bit output range.
  function automatic logic [OUT_W-1:0] sat_to_out(input logic signed [63:0] x);
    if (x > OUT_MAX) return 16'h7FFF;
    else if (x < OUT_MIN) return 16'h8000;
    else return x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/result_postproc.sv
// result_postproc: combinational bias add, fixed-point rescale, optional ReLU
// (macro RESULT_RELU_EN) and saturation to signed 16 bit.
module result_postproc
  import result_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [OUT_W-1:0] bias,
  output logic        [OUT_W-1:0] value
);

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      wide;

  // Bias is aligned to the accumulator's fraction bits before the rescale shift.
  always_comb begin
    bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
    sum      = acc + (bias_ext <<< SHIFT);
    shifted  = sum >>> SHIFT;
    wide     = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
`ifdef RESULT_RELU_EN
    if (wide[63]) wide = '0;
`else
`endif
    value    = sat_to_out(wide);
  end

endmodule

// File: rtl/result_accumulator.sv
// result_accumulator: accumulates IN_CH partial sums per output, post-processes
// each value and packs two 16-bit results per 32-bit result-memory write.
// Optional feature macro: RESULT_RELU_EN (clamps negative results to 0).
// psum handshake: a psum transfers on a rising edge where psum_valid and
// psum_ready are both 1; psum_ready is registered and only high in ACC, and
// psum_valid may drop at any time (the block simply waits).
module result_accumulator
  import result_pkg::*;
#(
  parameter int IN_CH = 4,
  parameter int SHIFT = 8,
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       out_total,
  input  logic [OUT_W-1:0]  bias,
  input  logic              psum_valid,
  input  logic [DATA_W-1:0] psum_data,
  output logic              psum_ready,
  output logic [DATA_W-1:0] write_result_data,
  output logic              write_result_signal,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CH_W = $clog2(IN_CH + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(IN_CH - 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
  logic [15:0]              out_cnt_q, out_cnt_d;
  logic [15:0]              out_total_q, out_total_d;
  logic [OUT_W-1:0]         bias_q, bias_d;
  logic [OUT_W-1:0]         low_q, low_d;
  logic                     half_q, half_d;
  logic                     psum_ready_q, psum_ready_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;
  logic                     wr_sig_q, wr_sig_d;
  logic                     done_q, done_d;

  logic signed [ACC_W-1:0]  psum_ext;
  logic [15:0]              out_cnt_inc;
  logic                     last_out;
  logic [OUT_W-1:0]         post_val;

  assign psum_ext    = {{(ACC_W-DATA_W){psum_data[DATA_W-1]}}, psum_data};
  assign out_cnt_inc = out_cnt_q + 16'd1;
  assign last_out    = (out_cnt_inc == out_total_q);

  result_postproc #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_postproc (
    .acc   (acc_q),
    .bias  (bias_q),
    .value (post_val)
  );

  // Next-state, datapath and registered-output computation for the pass FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ch_cnt_d    = ch_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_total_d = out_total_q;
    bias_d      = bias_q;
    low_d       = low_q;
    half_d      = half_q;
    wr_data_d   = wr_data_q;
    wr_sig_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          out_total_d = out_total;
          acc_d       = '0;
          ch_cnt_d    = '0;
          out_cnt_d   = '0;
          half_d      = 1'b0;
          state_d     = (out_total == 16'd0) ? FIN : ACC;
        end
      end
      ACC: begin
        if (psum_valid && psum_ready_q) begin
          acc_d    = acc_q + psum_ext;
          ch_cnt_d = ch_cnt_q + CH_W'(1);
          if (ch_cnt_q == '0) bias_d = bias;
          if (ch_cnt_q == CH_LAST) state_d = POST;
        end
      end
      POST: begin
        out_cnt_d = out_cnt_inc;
        acc_d     = '0;
        ch_cnt_d  = '0;
        if (half_q) begin
          wr_data_d = {post_val, low_q};
          wr_sig_d  = 1'b1;
          half_d    = 1'b0;
        end else if (last_out) begin
          // Odd output count: flush the lone value with a zero upper half.
          low_d     = post_val;
          wr_data_d = {16'h0000, post_val};
          wr_sig_d  = 1'b1;
        end else begin
          low_d  = post_val;
          half_d = 1'b1;
        end
        state_d = last_out ? FIN : ACC;
      end
      FIN: begin
        state_d = IDLE;
      end
    endcase
    psum_ready_d = (state_d == ACC);
    done_d       = (state_d == FIN);
  end

  // State and output registers; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ch_cnt_q     <= '0;
      out_cnt_q    <= '0;
      out_total_q  <= '0;
      bias_q       <= '0;
      low_q        <= '0;
      half_q       <= 1'b0;
      psum_ready_q <= 1'b0;
      wr_data_q    <= '0;
      wr_sig_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ch_cnt_q     <= ch_cnt_d;
      out_cnt_q    <= out_cnt_d;
      out_total_q  <= out_total_d;
      bias_q       <= bias_d;
      low_q        <= low_d;
      half_q       <= half_d;
      psum_ready_q <= psum_ready_d;
      wr_data_q    <= wr_data_d;
      wr_sig_q     <= wr_sig_d;
      done_q       <= done_d;
    end
  end

  assign psum_ready          = psum_ready_q;
  assign write_result_data   = wr_data_q;
  assign write_result_signal = wr_sig_q;
  assign done                = done_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: table vectors, randomized passes against an arithmetic
// reference model, and hand-written corner sequences for result_accumulator.
module tb_result_accumulator;
  import result_pkg::*;

  localparam int IN_CH = 4;
  localparam int SHIFT = 8;
  localparam int MAXO  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] out_total;
  logic [15:0] bias;
  logic        psum_valid;
  logic [31:0] psum_data;
  logic        psum_ready;
  logic [31:0] write_result_data;
  logic        write_result_signal;
  logic        done;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word = 32'h0;
  logic [31:0] ps[MAXO*IN_CH];
  logic [15:0] bs[MAXO];

  typedef struct {
    int          n_out;
    logic [31:0] p[12];
    logic [15:0] b[3];
    int          n_w;
    logic [31:0] w[2];
  } vec_t;
  vec_t tbl[3];

  // clock / reset
  always #5 clk = ~clk;

  result_accumulator #(.IN_CH(IN_CH), .SHIFT(SHIFT), .ACC_W(40)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .out_total           (out_total),
    .bias                (bias),
    .psum_valid          (psum_valid),
    .psum_data           (psum_data),
    .psum_ready          (psum_ready),
    .write_result_data   (write_result_data),
    .write_result_signal (write_result_signal),
    .done                (done),
    .dbg_state           (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && write_result_signal) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: got %h want no write", write_result_data);
      end else begin
        last_word = exp_q.pop_front();
        check("write_word", write_result_data, last_word);
      end
    end
  end

  // reference model: plain integer arithmetic on the whole output
  function automatic logic [15:0] model_val(input int o);
    longint s;
    s = longint'($signed(bs[o])) * (longint'(1) << SHIFT);
    for (int c = 0; c < IN_CH; c++) s += longint'($signed(ps[o*IN_CH+c]));
    s = s >>> SHIFT;
`ifdef RESULT_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic push_model(input int n_out);
    logic [15:0] v;
    logic [15:0] lo;
    lo = 16'h0;
    for (int o = 0; o < n_out; o++) begin
      v = model_val(o);
      if (o % 2 == 0) begin
        lo = v;
        if (o == n_out - 1) exp_q.push_back({16'h0000, v});
      end else begin
        exp_q.push_back({v, lo});
      end
    end
  endtask

  // driver: offer one psum until it is accepted (bounded)
  task automatic feed(input logic [31:0] d, input bit gaps, input bit scramble);
    int budget;
    bit taken;
    budget = 0;
    taken  = 1'b0;
    while (!taken && budget < 100) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) bias = 16'($urandom);
      psum_valid = !(gaps && $urandom_range(0, 2) == 0);
      psum_data  = psum_valid ? d : $urandom;
      taken      = psum_valid && psum_ready;
      budget++;
    end
    if (!taken) check("feed_timeout", 32'(taken), 32'd1);
  endtask

  // driver: one complete pass from ps/bs; poke pulses start during ACC
  task automatic run_pass(input int n_out, input bit gaps, input bit poke);
    int budget;
    bit got_done;
    @(negedge clk);
    out_total = 16'(n_out);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_total = 16'($urandom);
    for (int o = 0; o < n_out; o++) begin
      bias = bs[o];
      for (int c = 0; c < IN_CH; c++) begin
        if (poke && o == 0 && c == 2) begin
          start     = 1'b1;
          out_total = 16'h0000;
        end
        feed(ps[o*IN_CH+c], gaps, c != 0);
      end
      @(negedge clk);
      psum_valid = 1'b0;
      psum_data  = $urandom;
      check("ready_post", 32'(psum_ready), 32'd0);
    end
    got_done = 1'b0;
    budget   = 0;
    while (!got_done && budget < 4) begin
      @(negedge clk);
      budget++;
      if (done) got_done = 1'b1;
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("done_latency", 32'(budget), 32'd1);
    if (got_done) begin
      check("done_with_write", 32'(write_result_signal), 32'd1);
      check("ready_fin", 32'(psum_ready), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("ready_idle", 32'(psum_ready), 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("data_hold", write_result_data, last_word);
  endtask

  task automatic load_row(input int r);
    for (int i = 0; i < 3 * IN_CH; i++) ps[i] = tbl[r].p[i];
    for (int o = 0; o < 3; o++) bs[o] = tbl[r].b[o];
    for (int k = 0; k < tbl[r].n_w; k++) exp_q.push_back(tbl[r].w[k]);
  endtask

  task automatic fill_random(input int n_out);
    for (int i = 0; i < n_out * IN_CH; i++)
      ps[i] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 200000)) - 32'd100000);
    for (int o = 0; o < n_out; o++)
      bs[o] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'($urandom_range(0, 600)) - 16'd300);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; out_total = 16'h0; bias = 16'h0;
    psum_valid = 1'b0; psum_data = 32'h0;

    // table rows
    tbl[0].n_out = 2; tbl[0].n_w = 1;
    tbl[0].p[0] = 32'd256; tbl[0].p[1] = 32'd512; tbl[0].p[2] = 32'd768; tbl[0].p[3] = 32'd1024;
    for (int c = 4; c < 8; c++) tbl[0].p[c] = -32'sd256;
    tbl[0].b[0] = 16'd1; tbl[0].b[1] = 16'd0;
    tbl[1].n_out = 2; tbl[1].n_w = 1;
    for (int c = 0; c < 4; c++) tbl[1].p[c] = 32'h7FFF_FFFF;
    for (int c = 4; c < 8; c++) tbl[1].p[c] = 32'h8000_0000;
    tbl[1].b[0] = 16'd0; tbl[1].b[1] = 16'd0;
    tbl[2].n_out = 3; tbl[2].n_w = 2;
    for (int c = 0; c < 12; c++) tbl[2].p[c] = 32'd256;
    for (int o = 0; o < 3; o++) tbl[2].b[o] = 16'd0;
    tbl[2].w[0] = 32'h0004_0004; tbl[2].w[1] = 32'h0000_0004;
`ifdef RESULT_RELU_EN
    tbl[0].w[0] = 32'h0000_000B;
    tbl[1].w[0] = 32'h0000_7FFF;
`else
    tbl[0].w[0] = 32'hFFFC_000B;
    tbl[1].w[0] = 32'h8000_7FFF;
`endif

    // reset state
    #1;
    check("rst_ready", 32'(psum_ready), 32'd0);
    check("rst_wdata", write_result_data, 32'd0);
    check("rst_wsig", 32'(write_result_signal), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(psum_ready), 32'd0);

    // table-driven vectors, gap-free then with gaps
    for (int r = 0; r < 3; r++) begin
      load_row(r);
      run_pass(tbl[r].n_out, 1'b0, 1'b0);
    end
    load_row(0);
    run_pass(2, 1'b1, 1'b0);

    // out_total == 0: done without any write
    @(negedge clk); out_total = 16'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_ready", 32'(psum_ready), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd0);

    // start pulsed during ACC is ignored
    fill_random(2);
    push_model(2);
    run_pass(2, 1'b0, 1'b1);

    // reset mid-ACC abandons the pass
    fill_random(2);
    @(negedge clk); out_total = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0; bias = bs[0];
    for (int c = 0; c < 5; c++) feed(ps[c], 1'b0, c != 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(psum_ready), 32'd0);
    check("mid_rst_wdata", write_result_data, 32'd0);
    check("mid_rst_wsig", 32'(write_result_signal), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    psum_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    last_word = 32'h0;
    @(negedge clk);
    check("post_rst_ready", 32'(psum_ready), 32'd0);
    fill_random(3);
    push_model(3);
    run_pass(3, 1'b1, 1'b0);

    // randomized passes with valid gaps against the reference model
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 5);
      fill_random(n);
      push_model(n);
      run_pass(n, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
